// File: rtl/multu_hilo_unit.sv
// -----------------------------------------------------------------------------
// multu_hilo_unit
//
// Execute-stage multiply unit that serves the multu, mfhi and mflo
// instructions. It runs an iterative unsigned shift-add multiply of two
// WIDTH-bit operands, one partial product per clock. The 2*WIDTH-bit product
// is kept in the architectural HI/LO registers. While a multiply is running,
// the unit asks the pipeline to stall any instruction that needs the unit.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   start      in   EX-stage instruction is multu (already qualified by EX valid)
//   src_a      in   multiplicand (rs value), WIDTH bits
//   src_b      in   multiplier (rt value), WIDTH bits
//   mf_req     in   EX-stage instruction is mfhi or mflo
//   mf_sel_hi  in   1 = mfhi, 0 = mflo
//   mf_data    out  selected HI or LO value, combinational from the registers
//   hi         out  HI register (upper product half)
//   lo         out  LO register (lower product half)
//   busy       out  multiply in progress
//   done       out  one-cycle pulse in the cycle after HI/LO were written
//   stall      out  hold IF/ID/EX; busy & (mf_req | start)
//
// Handshake: start is a request with no ready signal. It is accepted on any
// rising edge where busy=0. A start that arrives while busy=1 is not accepted.
// Instead stall is raised so that the pipeline re-presents the instruction.
// mf_req follows the same pattern: the read is served in any cycle with
// stall=0.
// -----------------------------------------------------------------------------
module multu_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mf_req,
  input  logic             mf_sel_hi,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_LAST = CW'(1);

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_mcand;   // latched multiplicand
  logic [WIDTH:0]   r_acc;     // upper product half plus carry bit
  logic [WIDTH-1:0] r_shift;   // multiplier; low product bits shift in from the top
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic [WIDTH:0]   w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_acc_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_last;

  // The addend is added to the accumulator, and then {carry, acc, shift} is
  // shifted right by one. The accumulator is below 2^WIDTH after each shift,
  // so the (WIDTH+1)-bit sum cannot overflow.
  assign w_addend    = r_shift[0] ? {1'b0, r_mcand} : '0;
  assign w_sum       = r_acc + w_addend;
  assign w_acc_nxt   = {1'b0, w_sum[WIDTH:1]};
  assign w_shift_nxt = {w_sum[0], r_shift[WIDTH-1:1]};
  assign w_last      = (r_count == COUNT_LAST);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_shift <= '0;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= src_a;
            r_shift <= src_b;
            r_acc   <= '0;
            r_count <= COUNT_INIT;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_nxt;
          r_shift <= w_shift_nxt;
          r_count <= r_count - 1'b1;
          // The final iteration writes its result directly into HI/LO, so
          // the product is visible in the same cycle that busy falls.
          if (w_last) begin
            r_hi   <= w_acc_nxt[WIDTH-1:0];
            r_lo   <= w_shift_nxt;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = r_done;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign mf_data = mf_sel_hi ? r_hi : r_lo;
  // When start and mf_req are both high, the result is still just busy.
  assign stall   = busy & (mf_req | start);

endmodule

// File: tb/tb_multu_hilo_unit.sv
module tb_multu_hilo_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mf_req;
  logic             mf_sel_hi;
  logic [WIDTH-1:0] mf_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  int pass_cnt  = 0;
  int total_cnt = 0;

  multu_hilo_unit #(.WIDTH(WIDTH), .CW(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_a     (src_a),
    .src_b     (src_b),
    .mf_req    (mf_req),
    .mf_sel_hi (mf_sel_hi),
    .mf_data   (mf_data),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall     (stall)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Count the busy cycles after the accepted start edge. The loop is bounded,
  // so a hang shows up as a wrong count.
  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      step();
    end
  endtask

  // Full multiply: present start for one edge, then check the latency and the result.
  task automatic do_mult(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
    int cyc;
    start = 1'b1; src_a = a; src_b = b;
    step();
    start = 1'b0;
    wait_busy(cyc);
    check({tag, "_busy_cycles"}, 64'(cyc), 64'd32);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    step();
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; src_a = '0; src_b = '0; mf_req = 1'b0; mf_sel_hi = 1'b0;
    #12;
    rst = 1'b0;
    step();

    // reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_mf_data", 64'(mf_data), 64'd0);

    // basic products
    do_mult("m3x5", 32'd3, 32'd5, 32'h0, 32'h0000000F);
    do_mult("mmax", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

    // mfhi and mflo reads while idle: no stall, no latency
    mf_req = 1'b1; mf_sel_hi = 1'b1;
    #1;
    check("mfhi_idle_data", 64'(mf_data), 64'hFFFFFFFE);
    check("mfhi_idle_stall", 64'(stall), 64'd0);
    mf_sel_hi = 1'b0;
    #1;
    check("mflo_idle_data", 64'(mf_data), 64'h00000001);
    mf_req = 1'b0;
    step();

    do_mult("mzero", 32'h12345678, 32'h0, 32'h0, 32'h0);
    do_mult("m64k", 32'h00010000, 32'h00010000, 32'h00000001, 32'h0);

    // mflo stalls while busy
    start = 1'b1; src_a = 32'd7; src_b = 32'd6;
    step();
    start = 1'b0;
    step();
    mf_req = 1'b1; mf_sel_hi = 1'b0;
    #1;
    check("stall_hold_hi", 64'(hi), 64'h1);
    check("stall_hold_lo", 64'(lo), 64'h0);
    cyc = 0;
    while (stall === 1'b1 && cyc < 100) begin
      cyc++;
      step();
    end
    check("stall_cycles", 64'(cyc), 64'd31);
    check("stall_release_busy", 64'(busy), 64'd0);
    check("stall_release_data", 64'(mf_data), 64'h0000002A);
    check("stall_release_done", 64'(done), 64'd1);
    mf_req = 1'b0;
    step();

    // A start that arrives mid-run is ignored, and stall is raised while it is held
    start = 1'b1; src_a = 32'd9; src_b = 32'd10;
    step();
    start = 1'b0;
    step(); step(); step();
    start = 1'b1; src_a = 32'd100; src_b = 32'd100;
    #1;
    check("ign_start_stall0", 64'(stall), 64'd1);
    step();
    check("ign_start_stall1", 64'(stall), 64'd1);
    start = 1'b0; src_a = '0; src_b = '0;
    #1;
    check("ign_start_stall_drop", 64'(stall), 64'd0);
    wait_busy(cyc);
    check("ign_busy_cycles", 64'(cyc), 64'd28);
    check("ign_done", 64'(done), 64'd1);
    check("ign_lo", 64'(lo), 64'd90);
    check("ign_hi", 64'(hi), 64'd0);

    // back-to-back: a start in the done cycle is accepted at once
    start = 1'b1; src_a = 32'd4; src_b = 32'd5;
    #1;
    check("b2b_stall", 64'(stall), 64'd0);
    step();
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_busy(cyc);
    check("b2b_busy_cycles", 64'(cyc), 64'd32);
    check("b2b_lo", 64'(lo), 64'd20);
    step();

    // asynchronous reset during a run
    start = 1'b1; src_a = 32'hFFFF; src_b = 32'hFFFF;
    step();
    start = 1'b0;
    repeat (9) step();
    check("midrst_busy_before", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    #3;
    rst = 1'b0;
    step();
    check("midrst_still_idle", 64'(busy), 64'd0);
    do_mult("m2x2", 32'd2, 32'd2, 32'h0, 32'd4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/multu_hilo_unit.md
Name: multu_hilo_unit

Overview:
- Execute-stage neighbour of the ALU decoder: serves the multu, mflo and mfhi funct codes, which the decoder maps to a don't-care ALU control.
- Performs an iterative unsigned shift-add multiply of two WIDTH-bit operands and holds the 2*WIDTH-bit product in architectural HI/LO registers.
- Generates a pipeline stall when mfhi/mflo, or a second multu, arrives while a multiply is in progress.

Parameters:
- WIDTH, default 32: operand width; HI and LO are each WIDTH bits.
- CW, default 6: iteration counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  EX-stage instruction is multu (funct 6'b011001); qualified externally by EX valid
- src_a  in  WIDTH  multiplicand (rs value)
- src_b  in  WIDTH  multiplier (rt value)
- mf_req  in  1  EX-stage instruction is mfhi or mflo
- mf_sel_hi  in  1  1 = mfhi, 0 = mflo
- mf_data  out  WIDTH  selected HI or LO value, combinational from the registers
- hi  out  WIDTH  HI register (upper product half)
- lo  out  WIDTH  LO register (lower product half)
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse: HI/LO just updated
- stall  out  1  hold IF/ID/EX; equals busy & (mf_req | start)

Behaviour:
- Reset (asynchronous, any state, including mid-multiply):
  - state=IDLE; hi, lo, internal accumulator, shift and count registers = 0.
  - busy=0, done=0.
  - Any in-flight multiply is discarded.
- State machine states: IDLE, RUN.
- IDLE, start=1 at edge k:
  - Latch src_a into the multiplicand register and src_b into the multiplier/shift register.
  - Clear accumulator (WIDTH+1 bits, including carry).
  - count=WIDTH; state goes to RUN.
  - busy=1 for the cycle after edge k.
- RUN, each edge:
  - If shift[0]=1, accumulator upper WIDTH+1 bits += multiplicand.
  - Then shift {carry, acc, shift} right by 1; count decrements.
- RUN, edge where count reaches 0:
  - The iteration runs at edge k+WIDTH.
  - hi <= final accumulator high half; lo <= final shift register value.
  - state goes to IDLE; done=1 for exactly that one following cycle; busy=0 in that same cycle.
- Latency: WIDTH cycles with busy=1. Result visible on hi/lo/mf_data in the cycle after edge k+WIDTH.
- Arithmetic: unsigned only, no overflow. hi:lo equals src_a*src_b exactly, modulo 2^(2*WIDTH), which never wraps.
- HI/LO during RUN: hold the previous result. mf_data is valid only when busy=0.
- start while busy=1: ignored, with no re-latch and no effect on the current multiply. stall is asserted so the pipeline re-presents the instruction.
- start in the cycle done=1: accepted, since busy=0. This gives back-to-back multiplies with no bubble.
- mf_req while busy=1: stall=1 every cycle until busy falls. In the cycle busy falls, stall=0 and mf_data already shows the new product.
- mf_req with busy=0: stall=0; mf_data = mf_sel_hi ? hi : lo, with no added latency.
- start and mf_req together: the upstream decode makes this impossible. If it occurs anyway, start takes precedence and stall = busy.
- No outputs are X after reset. All state changes occur on the rising clk edge, except the asynchronous reset.

Test Plan:
- Reset, then start with src_a=3, src_b=5:
  - busy high for exactly 32 cycles.
  - done pulses once.
  - Then hi=0x00000000, lo=0x0000000F.
- src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- src_a=0x12345678, src_b=0 -> hi=lo=0. Then multiply 0x00010000 by 0x00010000 -> hi=0x00000001, lo=0.
- Stall on read while busy:
  - Stimulus: start 7*6, then assert mf_req with mf_sel_hi=0 on the next cycle and hold it.
  - stall must be 1 for 31 consecutive cycles, then 0.
  - mf_data must equal 0x0000002A on the first cycle stall=0.
  - Before completion, hi/lo must hold the previous result.
- Back-to-back and ignored starts:
  - Assert start mid-RUN with new operands: the result reflects only the first operands, and stall=1 while start is held.
  - Assert start in the done cycle: the second multiply begins immediately.
- Reset mid-multiply:
  - Assert rst asynchronously (off clock edge) at cycle 10 of a RUN.
  - Required: immediately busy=0, hi=lo=0, done=0.
  - A subsequent 2*2 gives lo=4 after 32 cycles.
